// File: rtl/i2s_sample_packer.sv
// i2s_sample_packer
//
// Pops samples from the I2S receiver's sample FIFO (first-word fall-through), narrows
// each one to 32, 16 or 8 bits and packs the results little-endian into 32-bit words.
// The words leave on a valid/ready stream. m_last marks the last word of a frame and
// m_keep marks which bytes of a flushed partial word are valid.
//
// Optional build macro: I2S_PACK_SATURATE_EN
//   When defined, 16/8-bit narrowing clamps to the signed range instead of truncating,
//   and the extra output sat_flag reports (sticky) that a clamp has occurred.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   en                   block enable; low returns to idle and drops any partial word
//   mode                 00: 1x32, 01: 2x16, 10: 4x8 lanes, 11: same as 00
//   frame_len            words per frame (0: m_last never asserted)
//   flush                pulse; emit the current partial word
//   fifo_empty/rdata/rd  FIFO read port
//   m_valid/ready/data/keep/last  output word stream
//   busy                 high whenever the packer is not idle
//   sat_flag             (I2S_PACK_SATURATE_EN only) sticky clamp indicator

`timescale 1ns/1ps

module i2s_sample_packer #(
    parameter int unsigned DW  = 32,
    parameter int unsigned FLW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [1:0]     mode,
    input  logic [FLW-1:0] frame_len,
    input  logic           flush,
    input  logic           fifo_empty,
    input  logic [DW-1:0]  fifo_rdata,
    output logic           fifo_rd,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [31:0]    m_data,
    output logic [3:0]     m_keep,
    output logic           m_last,
`ifdef I2S_PACK_SATURATE_EN
    output logic           sat_flag,
`endif
    output logic           busy
);

    typedef enum logic [1:0] {StIdle, StCollect, StHold} state_e;

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;    // stored normalised: 11 is kept as 00
    logic [1:0]     lane_q, lane_d;
    logic [31:0]    data_q, data_d;
    logic [3:0]     keep_q, keep_d;
    logic [FLW-1:0] frame_q, frame_d;

    logic [31:0] s32;
    logic [15:0] s16;
    logic [7:0]  s8;
    logic [1:0]  lane_last;
    logic [2:0]  filled;
    logic        last_word;
    logic        pop;

    // Byte enables for a word holding n filled lanes.
    function automatic logic [3:0] keep_for(input logic [1:0] m, input logic [2:0] n);
        logic [3:0] k;
        k = 4'hF;
        case (m)
            2'b01: k = (n >= 3'd2) ? 4'hF : 4'h3;
            2'b10: begin
                case (n)
                    3'd1:    k = 4'h1;
                    3'd2:    k = 4'h3;
                    3'd3:    k = 4'h7;
                    default: k = 4'hF;
                endcase
            end
            default: k = 4'hF;
        endcase
        return k;
    endfunction

    assign s32 = fifo_rdata[31:0];

`ifdef I2S_PACK_SATURATE_EN
    logic sat_q, sat_d;
    logic clamp16, clamp8;

    // The value fits in W signed bits only if every bit above W-1 equals the sign bit.
    assign clamp16 = (s32[31:15] != {17{s32[31]}});
    assign clamp8  = (s32[31:7] != {25{s32[31]}});
    assign s16 = clamp16 ? (s32[31] ? 16'h8000 : 16'h7FFF) : s32[15:0];
    assign s8  = clamp8 ? (s32[31] ? 8'h80 : 8'h7F) : s32[7:0];
    assign sat_flag = sat_q;
`else
    assign s16 = s32[15:0];
    assign s8  = s32[7:0];
`endif

    always_comb begin
        lane_last = 2'd0;
        case (mode_q)
            2'b01:   lane_last = 2'd1;
            2'b10:   lane_last = 2'd3;
            default: lane_last = 2'd0;
        endcase
    end

    assign last_word = (frame_len != '0) && (frame_q == frame_len - FLW'(1));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lane_d  = lane_q;
        data_d  = data_q;
        keep_d  = keep_q;
        frame_d = frame_q;
        filled  = {1'b0, lane_q};
        pop     = 1'b0;
`ifdef I2S_PACK_SATURATE_EN
        sat_d   = sat_q;
`endif
        if (!en) begin
            state_d = StIdle;
            lane_d  = 2'd0;
            data_d  = '0;
            keep_d  = 4'h0;
            frame_d = '0;
`ifdef I2S_PACK_SATURATE_EN
            sat_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCollect;
                    mode_d  = (mode == 2'b11) ? 2'b00 : mode;
                    lane_d  = 2'd0;
                    data_d  = '0;
                end
                StCollect: begin
                    pop = !fifo_empty;
                    if (pop) begin
                        case (mode_q)
                            2'b01:   data_d[{lane_q[0], 4'b0000} +: 16] = s16;
                            2'b10:   data_d[{lane_q, 3'b000} +: 8] = s8;
                            default: data_d = s32;
                        endcase
`ifdef I2S_PACK_SATURATE_EN
                        if ((mode_q == 2'b01 && clamp16) || (mode_q == 2'b10 && clamp8)) begin
                            sat_d = 1'b1;
                        end
`endif
                        lane_d = lane_q + 2'd1;
                        filled = {1'b0, lane_q} + 3'd1;
                        if (lane_q == lane_last) begin
                            state_d = StHold;
                            keep_d  = 4'hF;
                        end else if (flush) begin
                            // Pop is taken first; the now-partial word is flushed.
                            state_d = StHold;
                            keep_d  = keep_for(mode_q, filled);
                        end
                    end else if (flush && lane_q != 2'd0) begin
                        state_d = StHold;
                        keep_d  = keep_for(mode_q, filled);
                    end
                end
                StHold: begin
                    if (m_ready) begin
                        state_d = StCollect;
                        lane_d  = 2'd0;
                        data_d  = '0;
                        keep_d  = 4'h0;
                        frame_d = last_word ? '0 : frame_q + FLW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= 2'b00;
            lane_q  <= 2'd0;
            data_q  <= '0;
            keep_q  <= 4'h0;
            frame_q <= '0;
`ifdef I2S_PACK_SATURATE_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            frame_q <= frame_d;
`ifdef I2S_PACK_SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign fifo_rd = pop;
    assign m_valid = (state_q == StHold);
    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_last  = (state_q == StHold) && last_word;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_sample_packer.sv
// Directed bench for i2s_sample_packer: a queue-backed FIFO model feeds samples, expected
// words are queued as stimulus is driven and compared as the DUT hands them over.

`timescale 1ns/1ps

module tb_i2s_sample_packer;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, m_ready;
    logic [1:0]  mode;
    logic [7:0]  frame_len;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rdata = '0;
    logic        fifo_rd, m_valid, m_last, busy;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
`ifdef I2S_PACK_SATURATE_EN
    logic        sat_flag;
`endif

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    exp_t        exq[$];
    exp_t        cur;
    logic [31:0] fq[$];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;
    int          accepted = 0;

    always #5 clk = ~clk;

    i2s_sample_packer #(.DW(32), .FLW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mode       (mode),
        .frame_len  (frame_len),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
`ifdef I2S_PACK_SATURATE_EN
        .sat_flag   (sat_flag),
`endif
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // FIFO model: pop on the edge, present the new head from the falling edge on.
    always @(posedge clk) begin
        if (fifo_rd && fq.size() > 0) begin
            void'(fq.pop_front());
            pops++;
        end
    end

    // Output monitor: a handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        fifo_empty = (fq.size() == 0);
        fifo_rdata = fifo_empty ? 32'h0 : fq[0];
        #1;
        if (rst_n) begin
            if (fifo_rd) chk("rd_not_empty", 32'(fifo_empty), 32'd0);
            if (m_valid && m_ready) begin
                accepted++;
                chk("word_expected", 32'(exq.size() != 0), 32'd1);
                if (exq.size() != 0) begin
                    cur = exq.pop_front();
                    chk("data", m_data, cur.data);
                    chk("keep", 32'(m_keep), 32'(cur.keep));
                    chk("last", 32'(m_last), 32'(cur.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] x);
        fq.push_back(x);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
        e.data = d;
        e.keep = k;
        e.last = l;
        exq.push_back(e);
    endtask

    // Mode and frame length are only taken on leaving idle, so pass through idle.
    task automatic set_mode(input logic [1:0] m, input logic [7:0] fl);
        en = 1'b0;
        tick();
        mode = m;
        frame_len = fl;
        en = 1'b1;
        tick();
    endtask

    task automatic wait_pops(input int target);
        int t;
        t = 0;
        while (pops < target && t < 100) begin
            tick();
            t++;
        end
        chk("pops_reached", pops, target);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exq.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        tick();
        chk("drain", exq.size(), 0);
    endtask

    initial begin
        int base;
        int acc;
        int t;
        rst_n = 1'b0;
        en = 1'b0;
        mode = 2'b00;
        frame_len = 8'd0;
        flush = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_rd", 32'(fifo_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_keep", 32'(m_keep), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Two 16-bit lanes.
        m_ready = 1'b1;
        set_mode(2'b01, 8'd0);
        chk("collect_busy", 32'(busy), 32'd1);
        base = pops;
        push(32'h0000_1234);
        push(32'h0000_ABCD);
        expect_word(32'hABCD_1234, 4'hF, 1'b0);
        drain();
        chk("mode01_pops", pops - base, 2);

        // Flush with nothing collected must not emit.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("flush_empty_valid", 32'(m_valid), 32'd0);

        // Four 8-bit lanes, three filled then flushed.
        set_mode(2'b10, 8'd0);
        base = pops;
        push(32'h0000_0011);
        push(32'h0000_0022);
        push(32'h0000_0033);
        wait_pops(base + 3);
        flush = 1'b1;
        expect_word(32'h0033_2211, 4'h7, 1'b0);
        tick();
        flush = 1'b0;
        drain();

        // Flush in the same cycle as a pop: pop first, then a 1-lane partial word.
        push(32'h0000_005A);
        flush = 1'b1;
        expect_word(32'h0000_005A, 4'h1, 1'b0);
        tick();
        flush = 1'b0;
        drain();

        // One 16-bit lane flushed.
        set_mode(2'b01, 8'd0);
        base = pops;
        push(32'h0000_5555);
        wait_pops(base + 1);
        flush = 1'b1;
        expect_word(32'h0000_5555, 4'h3, 1'b0);
        tick();
        flush = 1'b0;
        drain();

        // Backpressure in 32-bit mode; a second sample waits in the FIFO meanwhile.
        set_mode(2'b00, 8'd0);
        m_ready = 1'b0;
        push(32'hDEAD_BEEF);
        expect_word(32'hDEAD_BEEF, 4'hF, 1'b0);
        t = 0;
        while (!m_valid && t < 20) begin
            tick();
            t++;
        end
        chk("bp_valid_up", 32'(m_valid), 32'd1);
        push(32'h0123_4567);
        expect_word(32'h0123_4567, 4'hF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_data", m_data, 32'hDEAD_BEEF);
            chk("bp_rd", 32'(fifo_rd), 32'd0);
            chk("bp_valid", 32'(m_valid), 32'd1);
        end
        acc = accepted;
        m_ready = 1'b1;
        tick();
        chk("bp_accept", accepted - acc, 1);
        drain();

        // Reserved mode behaves as 32-bit.
        set_mode(2'b11, 8'd0);
        push(32'hCAFE_F00D);
        expect_word(32'hCAFE_F00D, 4'hF, 1'b0);
        drain();

        // Framing: 3 words per frame, 7 words.
        set_mode(2'b00, 8'd3);
        for (int i = 0; i < 7; i++) begin
            push(32'h100 + 32'(i));
            expect_word(32'h100 + 32'(i), 4'hF, (i == 2 || i == 5));
        end
        drain();

        // Dropping en discards a partial word.
        set_mode(2'b10, 8'd0);
        base = pops;
        push(32'h0000_00A1);
        push(32'h0000_00A2);
        wait_pops(base + 2);
        en = 1'b0;
        tick();
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_valid", 32'(m_valid), 32'd0);
        chk("dis_rd", 32'(fifo_rd), 32'd0);
        en = 1'b1;
        push(32'h0000_0001);
        push(32'h0000_0002);
        push(32'h0000_0003);
        push(32'h0000_0004);
        expect_word(32'h0403_0201, 4'hF, 1'b0);
        drain();

        // Out-of-range 16-bit samples.
        set_mode(2'b01, 8'd0);
        push(32'h0001_0000);
        push(32'hFFFE_0000);
`ifdef I2S_PACK_SATURATE_EN
        expect_word(32'h8000_7FFF, 4'hF, 1'b0);
        drain();
        chk("sat_set", 32'(sat_flag), 32'd1);
        en = 1'b0;
        tick();
        chk("sat_clr", 32'(sat_flag), 32'd0);
`else
        expect_word(32'h0000_0000, 4'hF, 1'b0);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_sample_packer.md
Name: i2s_sample_packer

Overview:
Downstream consumer of the I2S receiver's sample FIFO. Pops conditioned samples from the FIFO read port and narrows each to 32, 16 or 8 bits. Packs them little-endian into 32-bit words and presents the words on a valid/ready stream toward a bus-master or DMA stage. Tags frame boundaries with m_last and partial words with m_keep.

Parameters:
DW, 32, FIFO data width; only bits [31:0] of fifo_rdata are used.
FLW, 8, width of frame_len and of the internal frame word counter.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
en  input  1  block enable; low forces IDLE and discards any partial word
mode  input  2  00: 1x32-bit lanes, 01: 2x16-bit, 10: 4x8-bit, 11: reserved (treated as 00)
frame_len  input  FLW  words per frame; 0 = m_last never asserted
flush  input  1  single-cycle pulse; emit the current partial word
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  DW  FIFO head word (first-word fall-through, valid while !fifo_empty)
fifo_rd  output  1  pop strobe, one sample per cycle
m_valid  output  1  output word valid
m_ready  input  1  downstream accept
m_data  output  32  packed word
m_keep  output  4  byte enables of m_data
m_last  output  1  last word of frame
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low at posedge clk): state=IDLE. fifo_rd=0, m_valid=0, m_data=0, m_keep=0, m_last=0, busy=0. lane_idx=0, frame_ctr=0.
- Lane count N: 1 / 2 / 4 for mode 00 / 01 / 10. mode is latched as mode_q on IDLE->COLLECT. Changes while busy are ignored.
- States: IDLE, COLLECT, HOLD.
- IDLE -> COLLECT when en=1. Clears lane_idx and the data register.
- COLLECT:
  - fifo_rd = en & !fifo_empty (combinational).
  - On each pop, the narrowed sample is written to lane lane_idx: bits [W*lane_idx +: W], where W = 32/N. lane_idx then increments.
  - When the pop fills lane N-1: next cycle state=HOLD, m_valid=1, m_keep=4'hF.
- Narrowing (no macro): keep fifo_rdata[W-1:0], i.e. truncate upper bits.
- flush in COLLECT with lane_idx>0 and no pop this cycle: go to HOLD. Unfilled lanes are 0. m_keep covers only filled lanes (mode 01 with 1 lane -> 4'h3; mode 10 with 3 lanes -> 4'h7).
- flush in COLLECT with lane_idx=0: ignored.
- flush coinciding with a pop: the pop is taken first; flush applies only if the word is still partial after it, and then takes effect in that same cycle.
- flush in IDLE or HOLD: ignored, not remembered.
- HOLD:
  - m_data, m_keep and m_last are stable while m_valid=1 and m_ready=0.
  - fifo_rd=0.
  - On m_valid & m_ready: next cycle m_valid=0, lane_idx=0, data register cleared, state=COLLECT.
  - Sustained throughput is one word per N+1 cycles.
- Framing:
  - m_last = (frame_len!=0) & (frame_ctr==frame_len-1) while in HOLD.
  - frame_ctr increments on each accepted word and wraps to 0 after the m_last word. Flushed words count as normal words.
- en=0 in any state: next cycle IDLE. m_valid dropped without a handshake, partial word lost, frame_ctr cleared, fifo_rd=0 in that same cycle.
- Synchronous reset mid-operation has the same effect as en=0, plus the reset values above.
- fifo_rd is never asserted while fifo_empty=1 or in HOLD, so underflow is impossible.

Optional Feature:
Macro I2S_PACK_SATURATE_EN.
- Defined: narrowing treats fifo_rdata as signed 32-bit and clamps to the signed range of W bits.
  - 16-bit: >32767 -> 16'h7FFF, <-32768 -> 16'h8000.
  - 8-bit: 8'h7F / 8'h80.
  - Mode 00 unchanged.
  - Adds output sat_flag (1 bit): sticky, set on any clamp, cleared by reset or when en=0.
- Undefined: plain truncation, and sat_flag does not exist.

Test Plan:
- Reset/idle: rst_n=0 for 2 clk, en=0 -> m_valid=0, fifo_rd=0, busy=0, m_keep=0.
- Mode 01, FIFO holds 32'h0000_1234 then 32'h0000_ABCD, m_ready=1 -> one word m_data=32'hABCD_1234, m_keep=4'hF, exactly 2 fifo_rd pulses.
- Mode 10, 3 samples 8'h11, 8'h22, 8'h33 then flush -> m_data=32'h0033_2211, m_keep=4'h7.
- Backpressure: mode 00, m_ready=0 for 5 cycles -> m_data stable, fifo_rd=0 throughout, word accepted on the first m_ready=1 cycle.
- Framing: frame_len=3, 7 words in mode 00 -> m_last asserted on words 3 and 6 only.
- With I2S_PACK_SATURATE_EN, mode 01, inputs 32'h0001_0000 and 32'hFFFE_0000 -> m_data=32'h8000_7FFF, sat_flag=1. Without the macro -> m_data=32'h0000_0000.
